// File: rtl/fpnew_cast_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_cast_result_buffer
// Purpose : Decoupling FIFO behind the int-to-float cast unit. Buffers
//           {result, status, ext, tag}, NaN-boxes the head result to
//           OutWidth and accumulates sticky exception flags on retirement.
// Options : FPNEW_CAST_BUF_BYPASS_EN - zero-latency path when the FIFO is
//           empty (default build is purely buffered, 1-cycle latency).
// Rev     : 1.0 - initial release
// ============================================================================
module fpnew_cast_result_buffer #(
    parameter int unsigned Width    = 32,
    parameter int unsigned OutWidth = 64,
    parameter int unsigned Depth    = 4,
    parameter int unsigned TagWidth = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [Width-1:0]         result_i,
    input  logic [4:0]               status_i,
    input  logic                     extension_bit_i,
    input  logic [TagWidth-1:0]      tag_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [OutWidth-1:0]      result_o,
    output logic [4:0]               status_o,
    output logic [TagWidth-1:0]      tag_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [4:0]               fflags_o,
    input  logic                     fflags_clr_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     busy_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [Width-1:0]    result;
        logic [4:0]          status;
        logic                ext;
        logic [TagWidth-1:0] tag;
    } entry_t;

    entry_t          mem_q [Depth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      fflags_q, fflags_d;

    entry_t          in_entry;
    entry_t          head_sel;
    entry_t          head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            byp_active;
    logic            byp_pop;
    logic            wr_en;
    logic            rd_en;

    assign in_entry = '{result: result_i, status: status_i,
                        ext: extension_bit_i, tag: tag_i};

    // Wrap bit distinguishes full from empty when the addresses coincide.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready never looks at out_ready_i, so no comb path downstream-to-upstream.
    assign in_ready_o = ~full & ~flush_i;
    assign push       = in_valid_i & in_ready_o;

`ifdef FPNEW_CAST_BUF_BYPASS_EN
    // An accepted input on an empty FIFO is presented straight away.
    assign byp_active = empty & push;
`else
    assign byp_active = 1'b0;
`endif

    assign out_valid_o = ~empty | byp_active;
    assign pop         = out_valid_o & out_ready_i;
    assign byp_pop     = byp_active & out_ready_i;
    // A bypassed entry that is consumed immediately never touches storage.
    assign wr_en       = push & ~byp_pop;
    assign rd_en       = pop & ~byp_active;

    // Head is forced to zero while nothing is valid so the outputs are
    // defined straight out of reset even though storage is not.
    assign head_sel = byp_active ? in_entry : mem_q[rd_ptr_q[AW-1:0]];
    assign head     = out_valid_o ? head_sel : '0;

    assign status_o = head.status;
    assign tag_o    = head.tag;

    generate
        if (OutWidth == Width) begin : g_passthru
            assign result_o = head.result;
        end else begin : g_nanbox
            assign result_o = {{(OutWidth-Width){head.ext}}, head.result};
        end
    endgenerate

    // Pointer next-state: flush resets both, otherwise advance on handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Sticky flags: clear wins over accumulate; a clear coinciding with a
    // pop keeps the popped status. Flush leaves the flags alone.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i && pop) begin
            fflags_d = head.status;
        end else if (fflags_clr_i) begin
            fflags_d = 5'b0;
        end else if (pop) begin
            fflags_d = fflags_q | head.status;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fflags_q <= 5'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fflags_q <= fflags_d;
        end
    end

    // Entry storage, intentionally without reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
        end
    end

    assign fflags_o = fflags_q;
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign busy_o   = (count_o != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpnew_cast_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpnew_cast_result_buffer
// Purpose : Directed self-checking bench for fpnew_cast_result_buffer with a
//           queue-based reference model checked every falling edge.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_fpnew_cast_result_buffer;

`ifdef FPNEW_CAST_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] result_i = '0;
    logic [4:0]  status_i = '0;
    logic        extension_bit_i = 1'b0;
    logic [0:0]  tag_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic [63:0] result_o;
    logic [4:0]  status_o;
    logic [0:0]  tag_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 1'b0;
    logic [2:0]  count_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    fpnew_cast_result_buffer #(
        .Width(32), .OutWidth(64), .Depth(DEPTH), .TagWidth(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .result_i(result_i), .status_i(status_i),
        .extension_bit_i(extension_bit_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
        .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] res;
        logic [4:0]  st;
        logic        ext;
        logic        tag;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] m_fflags = '0;

    // Checks DUT outputs against the model, then advances the model by the
    // handshakes that will happen at the coming rising edge.
    always @(negedge clk_i) begin
        ent_t hd;
        bit   e_ready, e_push, e_byp, e_valid, e_pop;
        if (!rst_ni) begin
            mq.delete();
            m_fflags = '0;
            chk("rst_out_valid", {63'b0, out_valid_o}, 64'd0);
            chk("rst_in_ready", {63'b0, in_ready_o}, 64'd1);
            chk("rst_count", {61'b0, count_o}, 64'd0);
            chk("rst_busy", {63'b0, busy_o}, 64'd0);
            chk("rst_fflags", {59'b0, fflags_o}, 64'd0);
            chk("rst_result", result_o, 64'd0);
            chk("rst_status_tag", {58'b0, status_o, tag_o}, 64'd0);
        end else begin
            e_ready = (mq.size() < DEPTH) && !flush_i;
            e_push  = in_valid_i && e_ready;
            e_byp   = BYP && (mq.size() == 0) && e_push;
            e_valid = (mq.size() > 0) || e_byp;
            if (e_byp) hd = '{res: result_i, st: status_i, ext: extension_bit_i, tag: tag_i[0]};
            else if (mq.size() > 0) hd = mq[0];
            else hd = '{res: '0, st: '0, ext: 1'b0, tag: 1'b0};
            e_pop = e_valid && out_ready_i;

            chk("out_valid", {63'b0, out_valid_o}, {63'b0, e_valid});
            chk("in_ready", {63'b0, in_ready_o}, {63'b0, e_ready});
            chk("count", {61'b0, count_o}, 64'(mq.size()));
            chk("busy", {63'b0, busy_o}, {63'b0, mq.size() != 0});
            chk("fflags", {59'b0, fflags_o}, {59'b0, m_fflags});
            if (e_valid) begin
                chk("result", result_o, {{32{hd.ext}}, hd.res});
                chk("status", {59'b0, status_o}, {59'b0, hd.st});
                chk("tag", {63'b0, tag_o}, {63'b0, hd.tag});
            end

            if (fflags_clr_i && e_pop)  m_fflags = hd.st;
            else if (fflags_clr_i)      m_fflags = '0;
            else if (e_pop)             m_fflags = m_fflags | hd.st;

            if (flush_i) begin
                mq.delete();
            end else begin
                if (e_pop && !e_byp) void'(mq.pop_front());
                if (e_push && !(e_byp && e_pop))
                    mq.push_back('{res: result_i, st: status_i, ext: extension_bit_i, tag: tag_i[0]});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [4:0] s, input logic e, input logic t);
        in_valid_i = 1'b1;
        result_i = r;
        status_i = s;
        extension_bit_i = e;
        tag_i = t;
    endtask

    initial begin
        repeat (2) step();
        rst_ni = 1'b1;
        step();

        // Single push/pop with NaN-boxing.
        out_ready_i = 1'b1;
        drive(32'h3F80_0000, 5'h01, 1'b1, 1'b1);
        step();
        in_valid_i = 1'b0;
        #2;
        chk("t1_valid", {63'b0, out_valid_o}, 64'd1);
        chk("t1_result", result_o, 64'hFFFF_FFFF_3F80_0000);
        chk("t1_tag", {63'b0, tag_o}, 64'd1);
        step();
        #2;
        chk("t1_fflags", {59'b0, fflags_o}, 64'h01);
        chk("t1_count", {61'b0, count_o}, 64'd0);

        // Fill beyond capacity with the consumer stalled.
        step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h0000_1000 + i, 5'h00, i[0], i[0]);
            step();
        end
        #2;
        chk("t2_count_full", {61'b0, count_o}, 64'd4);
        chk("t2_ready_full", {63'b0, in_ready_o}, 64'd0);
        out_ready_i = 1'b1;
        step();
        step();
        in_valid_i = 1'b0;
        repeat (6) step();
        #2;
        chk("t2_drained", {61'b0, count_o}, 64'd0);

        // Streaming push+pop across the pointer wrap.
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'hA000_0000 + i, (i % 3 == 0) ? 5'h10 : ((i % 3 == 1) ? 5'h01 : 5'h00),
                  1'b0, i[0]);
            step();
            #2;
            chk("t3_count", {61'b0, count_o}, 64'd1);
        end
        in_valid_i = 1'b0;
        step();
        #2;
        chk("t3_fflags", {59'b0, fflags_o}, 64'h11);

        // Flush with three entries buffered.
        step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h5555_0000 + i, 5'h08, 1'b1, 1'b0);
            step();
        end
        flush_i = 1'b1;
        #2;
        chk("t4_ready_flush", {63'b0, in_ready_o}, 64'd0);
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        #2;
        chk("t4_valid", {63'b0, out_valid_o}, 64'd0);
        chk("t4_count", {61'b0, count_o}, 64'd0);
        chk("t4_busy", {63'b0, busy_o}, 64'd0);
        chk("t4_fflags", {59'b0, fflags_o}, 64'h11);

        // Sticky clear, alone and together with a pop.
        step();
        out_ready_i = 1'b1;
        drive(32'h1234_5678, 5'h1F, 1'b0, 1'b0);
        step();
        in_valid_i = 1'b0;
        step();
        #2;
        chk("t5_fflags_all", {59'b0, fflags_o}, 64'h1F);
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        #2;
        chk("t5_fflags_clr", {59'b0, fflags_o}, 64'h00);
        out_ready_i = 1'b0;
        drive(32'h0000_0002, 5'h02, 1'b0, 1'b0);
        step();
        drive(32'h0000_0004, 5'h04, 1'b0, 1'b1);
        step();
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        out_ready_i = 1'b0;
        #2;
        chk("t5_fflags_clr_pop", {59'b0, fflags_o}, 64'h04);
        chk("t5_count", {61'b0, count_o}, 64'd0);

`ifdef FPNEW_CAST_BUF_BYPASS_EN
        // Zero-latency bypass on an empty FIFO.
        step();
        out_ready_i = 1'b1;
        drive(32'h4000_0000, 5'h00, 1'b0, 1'b0);
        #2;
        chk("t6_valid", {63'b0, out_valid_o}, 64'd1);
        chk("t6_result", result_o, 64'h0000_0000_4000_0000);
        chk("t6_count", {61'b0, count_o}, 64'd0);
        step();
        in_valid_i = 1'b0;
        #2;
        chk("t6_count_after", {61'b0, count_o}, 64'd0);
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
